// File: rtl/sm_icache.sv
// sm_icache: direct-mapped read-only instruction cache, line refill.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module sm_icache #(
  parameter int ADDR_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG   = ADDR_W - IDX - OFF;
  localparam int DEPTH = LINES * WORDS_PER_LINE;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG-1:0]     lat_tag_q, lat_tag_d;
  logic [IDX-1:0]     lat_idx_q, lat_idx_d;
  logic [OFF-1:0]     beat_q, beat_d;
  logic               flushed_q, flushed_d;
  logic               data_we;
  logic               tag_we;

  logic [TAG-1:0]     tag_q  [LINES];
  logic [31:0]        data_q [DEPTH];

  logic [OFF-1:0]     cpu_off;
  logic [IDX-1:0]     cpu_idx;
  logic [TAG-1:0]     cpu_tag;
  logic               hit;
  logic               last;

  assign cpu_off = cpu_addr[OFF-1:0];
  assign cpu_idx = cpu_addr[OFF +: IDX];
  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG];

  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign cpu_ready = (state_q == IDLE) && cpu_req && hit && !flush;
  assign cpu_rdata = data_q[{cpu_idx, cpu_off}];

  assign last     = (beat_q == OFF'(WORDS_PER_LINE - 1));
  assign mem_req  = (state_q == REFILL);
  assign mem_addr = mem_req ? {lat_tag_q, lat_idx_q, beat_q} : '0;

  // Lookup/refill control: next state, valid bits, latched line, beat.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    lat_tag_d = lat_tag_q;
    lat_idx_d = lat_idx_q;
    beat_d    = beat_q;
    flushed_d = flushed_q;
    data_we   = 1'b0;
    tag_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (cpu_req && !hit) begin
          lat_tag_d        = cpu_tag;
          lat_idx_d        = cpu_idx;
          beat_d           = '0;
          flushed_d        = 1'b0;
          valid_d[cpu_idx] = 1'b0;
          state_d          = REFILL;
        end
      end
      REFILL: begin
        if (flush) begin
          valid_d   = '0;
          flushed_d = 1'b1;
        end
        if (mem_ack) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFF'(1);
          if (last) begin
            tag_we             = 1'b1;
            valid_d[lat_idx_q] = !(flushed_q || flush);
            state_d            = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
      beat_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      lat_tag_q <= lat_tag_d;
      lat_idx_q <= lat_idx_d;
      beat_q    <= beat_d;
      flushed_q <= flushed_d;
    end
  end

  // Tag and data arrays: contents need no reset, valid bits guard them.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[{lat_idx_q, beat_q}] <= mem_rdata;
    end
    if (tag_we) begin
      tag_q[lat_idx_q] <= lat_tag_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic        miss_start;

  assign miss_start  = (state_q == IDLE) && cpu_req && !hit && !flush;
  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;

  // Free-running wrapping counters; flush leaves them alone.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (cpu_ready) begin
      hits_d = hits_q + 32'd1;
    end
    if (miss_start) begin
      misses_d = misses_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end
`endif

endmodule

// File: tb/tb_sm_icache.sv
// tb_sm_icache: directed, table-driven and randomized checks of sm_icache.
// Memory responder acks every `period` cycles; model tracks line contents.
module tb_sm_icache;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        cpu_req = 0;
  logic [31:0] cpu_addr = 0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        flush = 0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 0;
  logic        mem_ack = 0;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int period  = 1;
  bit spur_en = 0;
  int wait_cnt = 0;
  logic        prev_req = 0;
  logic        prev_ack = 0;
  logic [31:0] prev_addr = 0;
  logic [31:0] beats[$];

  sm_icache #(
    .ADDR_W(32), .LINES(16), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ICACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'h100 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: ack every `period` cycles of mem_req, junk acks when idle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (prev_req && !prev_ack)
        chk("hold_addr", mem_addr, prev_addr);
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= period) begin
        mem_ack   = 1;
        mem_rdata = memval(mem_addr);
        beats.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 0;
        mem_rdata = $urandom;
      end
    end else begin
      wait_cnt  = 0;
      mem_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
    prev_req  = mem_req;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
  end

  // Request addr until cpu_ready; cyc = cycles after the lookup cycle.
  task automatic fetch(input logic [31:0] a, output int cyc,
                       output logic [31:0] d);
    cyc = 0;
    @(negedge clk);
    cpu_req  = 1;
    cpu_addr = a;
    #1;
    while (!cpu_ready && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("fetch_done", {31'b0, cpu_ready}, 32'd1);
    d = cpu_rdata;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        exp_ready;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[6];

  logic [25:0] m_tag[16];
  bit          m_val[16];

  initial begin
    int          cyc;
    int          g;
    logic [31:0] d;

    vt[0] = '{1'b1, 32'h5,  1'b1, 32'h105};
    vt[1] = '{1'b1, 32'h6,  1'b1, 32'h106};
    vt[2] = '{1'b1, 32'h7,  1'b1, 32'h107};
    vt[3] = '{1'b1, 32'h4,  1'b1, 32'h104};
    vt[4] = '{1'b0, 32'h5,  1'b0, 32'h0};
    vt[5] = '{1'b1, 32'h44, 1'b0, 32'h0};

    // Reset values while a request is pending.
    cpu_req  = 1;
    cpu_addr = 32'h4;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", {31'b0, cpu_ready}, 0);
`ifdef ICACHE_STATS_EN
    chk("rst_hits", stat_hits, 0);
    chk("rst_misses", stat_misses, 0);
`endif
    cpu_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    // 1: cold miss on 0x4.
    beats.delete();
    period = 1;
    fetch(32'h4, cyc, d);
    chk("t1_cycles", cyc, 5);
    chk("t1_data", d, 32'h104);
    chk("t1_mem_req", {31'b0, mem_req}, 0);
    chk("t1_nbeats", beats.size(), 4);
    for (int i = 0; i < beats.size(); i++)
      chk("t1_beat", beats[i], 32'h4 + i);

    // 2/3: table of hits, then a conflict miss on 0x44.
    beats.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef ICACHE_STATS_EN
      if (i == 3) begin
        chk("t6_hits", stat_hits, 4);
        chk("t6_misses", stat_misses, 1);
      end
`endif
      cpu_req  = vt[i].req;
      cpu_addr = vt[i].addr;
      #1;
      chk("tbl_ready", {31'b0, cpu_ready}, {31'b0, vt[i].exp_ready});
      if (vt[i].exp_ready)
        chk("tbl_data", cpu_rdata, vt[i].exp_data);
      chk("tbl_mem_req", {31'b0, mem_req}, 0);
    end
    fetch(32'h44, cyc, d);
    chk("t3_data", d, 32'h144);
    chk("t3_nbeats", beats.size(), 4);
    for (int i = 0; i < beats.size(); i++)
      chk("t3_beat", beats[i], 32'h44 + i);
    fetch(32'h4, cyc, d);
    chk("t3_remiss", cyc, 5);
    chk("t3_redata", d, 32'h104);

    // 4: stalled memory, ack every third cycle.
    beats.delete();
    period = 3;
    fetch(32'h1230, cyc, d);
    chk("t4_cycles", cyc, 13);
    chk("t4_data", d, 32'h1330);
    chk("t4_nbeats", beats.size(), 4);
    for (int i = 0; i < beats.size(); i++)
      chk("t4_beat", beats[i], 32'h1230 + i);
    period = 1;

    // Flush in IDLE: no hit in the flush cycle, line gone afterwards.
    @(negedge clk);
    cpu_addr = 32'h5;
    flush    = 1;
    #1;
    chk("fl_idle_ready", {31'b0, cpu_ready}, 0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("fl_idle_miss", {31'b0, cpu_ready}, 0);
    fetch(32'h5, cyc, d);
    chk("fl_idle_data", d, 32'h105);

    // 5a: flush mid-refill.
    beats.delete();
    @(negedge clk);
    cpu_req  = 1;
    cpu_addr = 32'h200;
    g = 0;
    while (beats.size() < 2 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    g = 0;
    while (mem_req && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("t5a_burst", beats.size(), 4);
    chk("t5a_invalid", {31'b0, cpu_ready}, 0);
    fetch(32'h200, cyc, d);
    chk("t5a_data", d, 32'h300);
    fetch(32'h4, cyc, d);
    chk("t5a_remiss", cyc, 5);

    // 5b: reset mid-refill.
    beats.delete();
    @(negedge clk);
    cpu_req  = 1;
    cpu_addr = 32'h300;
    g = 0;
    while (beats.size() < 1 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    rst_n = 0;
    #1;
    chk("t5b_mem_req", {31'b0, mem_req}, 0);
    chk("t5b_mem_addr", mem_addr, 0);
    chk("t5b_ready", {31'b0, cpu_ready}, 0);
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    rst_n = 1;
    fetch(32'h4, cyc, d);
    chk("t5b_remiss", cyc, 5);
    fetch(32'h300, cyc, d);
    chk("t5b_partial", cyc, 5);
    chk("t5b_data", d, 32'h400);

    // Randomized fetches/flushes against a line-set model.
    @(negedge clk);
    cpu_req = 0;
    flush   = 1;
    @(negedge clk);
    flush = 0;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    spur_en = 1;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic [3:0]  ix;
      logic        h;
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        cpu_req = $urandom_range(0, 1);
        flush   = 1;
        @(negedge clk);
        flush   = 0;
        cpu_req = 0;
        for (int i = 0; i < 16; i++) m_val[i] = 0;
      end
      a      = 32'($urandom_range(0, 255));
      a[28]  = 1'($urandom_range(0, 1));
      ix     = a[5:2];
      h      = m_val[ix] && (m_tag[ix] == a[31:6]);
      period = $urandom_range(1, 3);
      fetch(a, cyc, d);
      chk("rnd_cycles", cyc, h ? 0 : 4 * period + 1);
      chk("rnd_data", d, memval(a));
      m_val[ix] = 1;
      m_tag[ix] = a[31:6];
    end
    spur_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
